// File: rtl/id_ex_stage_pkg.sv
// Shared definitions for the ID/EX stage: ALUOp codes, forward-select encodings and a hit helper.
// Forwarding from MEM/WB is compiled in only when EX_FWD_EN is defined.
package id_ex_stage_pkg;

  localparam int unsigned RegAddrW = 5;

  typedef enum logic [4:0] {
    AluAdd  = 5'd0,
    AluSub  = 5'd1,
    AluSll  = 5'd2,
    AluSlt  = 5'd3,
    AluSltu = 5'd4,
    AluXor  = 5'd5,
    AluSrl  = 5'd6,
    AluSra  = 5'd7,
    AluOr   = 5'd8,
    AluAnd  = 5'd9,
    AluLui  = 5'd10
  } alu_op_e;

  typedef enum logic [1:0] {
    FwdReg = 2'b00,
    FwdMem = 2'b01,
    FwdWb  = 2'b10
  } fwd_sel_e;

  // A non-zero destination that matches either ID source; unused sources still count.
  function automatic logic rd_hits(logic [RegAddrW-1:0] rd, logic [RegAddrW-1:0] rs1,
                                   logic [RegAddrW-1:0] rs2);
    return (rd != '0) && ((rd == rs1) || (rd == rs2));
  endfunction

endpackage

// File: rtl/id_ex_stage_if.sv
// Bundle of ID-side inputs, MEM/WB forwarding sources and EX-side outputs of id_ex_stage.
// The slave modport is the stage itself; master is the surrounding pipeline.
interface id_ex_stage_if #(
  parameter int unsigned XLEN = 32,
  parameter int unsigned OPW  = 5
);
  logic            id_valid;
  logic [XLEN-1:0] id_pc;
  logic [4:0]      id_rs1_addr;
  logic [4:0]      id_rs2_addr;
  logic [XLEN-1:0] id_rs1_data;
  logic [XLEN-1:0] id_rs2_data;
  logic [XLEN-1:0] id_imm;
  logic [4:0]      id_rd_addr;
  logic [OPW-1:0]  id_alu_op;
  logic            id_src1_pc;
  logic            id_src2_imm;
  logic            id_reg_write;
  logic            id_mem_read;
  logic            id_mem_write;
  logic            ex_hold;
  logic            ex_flush;
  logic            mem_reg_write;
  logic [4:0]      mem_rd_addr;
  logic [XLEN-1:0] mem_rd_data;
  logic            wb_reg_write;
  logic [4:0]      wb_rd_addr;
  logic [XLEN-1:0] wb_rd_data;
  logic            ex_valid;
  logic [OPW-1:0]  ex_alu_op;
  logic [XLEN-1:0] ex_op1;
  logic [XLEN-1:0] ex_op2;
  logic [XLEN-1:0] ex_store_data;
  logic [4:0]      ex_rd_addr;
  logic            ex_reg_write;
  logic            ex_mem_read;
  logic            ex_mem_write;
  logic [XLEN-1:0] ex_pc;
  logic            load_use_stall;

  modport master (
    output id_valid, id_pc, id_rs1_addr, id_rs2_addr, id_rs1_data, id_rs2_data, id_imm,
           id_rd_addr, id_alu_op, id_src1_pc, id_src2_imm, id_reg_write, id_mem_read,
           id_mem_write, ex_hold, ex_flush, mem_reg_write, mem_rd_addr, mem_rd_data,
           wb_reg_write, wb_rd_addr, wb_rd_data,
    input  ex_valid, ex_alu_op, ex_op1, ex_op2, ex_store_data, ex_rd_addr, ex_reg_write,
           ex_mem_read, ex_mem_write, ex_pc, load_use_stall
  );

  modport slave (
    input  id_valid, id_pc, id_rs1_addr, id_rs2_addr, id_rs1_data, id_rs2_data, id_imm,
           id_rd_addr, id_alu_op, id_src1_pc, id_src2_imm, id_reg_write, id_mem_read,
           id_mem_write, ex_hold, ex_flush, mem_reg_write, mem_rd_addr, mem_rd_data,
           wb_reg_write, wb_rd_addr, wb_rd_data,
    output ex_valid, ex_alu_op, ex_op1, ex_op2, ex_store_data, ex_rd_addr, ex_reg_write,
           ex_mem_read, ex_mem_write, ex_pc, load_use_stall
  );

endinterface

// File: rtl/ex_fwd_mux.sv
// Per-operand forwarding select: MEM result beats WB data beats the registered read data.
// x0 is never forwarded.
module ex_fwd_mux
  import id_ex_stage_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic [RegAddrW-1:0] rs_addr,
  input  logic [XLEN-1:0]     reg_data,
  input  logic                mem_reg_write,
  input  logic [RegAddrW-1:0] mem_rd_addr,
  input  logic [XLEN-1:0]     mem_rd_data,
  input  logic                wb_reg_write,
  input  logic [RegAddrW-1:0] wb_rd_addr,
  input  logic [XLEN-1:0]     wb_rd_data,
  output logic [XLEN-1:0]     fwd_data
);

  fwd_sel_e sel;

  always_comb begin
    sel = FwdReg;
    if (rs_addr != '0) begin
      if (mem_reg_write && (mem_rd_addr == rs_addr)) begin
        sel = FwdMem;
      end else if (wb_reg_write && (wb_rd_addr == rs_addr)) begin
        sel = FwdWb;
      end
    end
  end

  always_comb begin
    fwd_data = reg_data;
    unique case (sel)
      FwdMem:  fwd_data = mem_rd_data;
      FwdWb:   fwd_data = wb_rd_data;
      default: fwd_data = reg_data;
    endcase
  end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with EX-side operand selection and load-use bubble insertion.
// Define EX_FWD_EN for MEM/WB forwarding; otherwise any pending writer stalls ID.
module id_ex_stage
  import id_ex_stage_pkg::*;
#(
  parameter int unsigned XLEN = 32,
  parameter int unsigned OPW  = 5
) (
  input logic         clk,
  input logic         rst,
  id_ex_stage_if.slave bus
);

  logic            valid_q;
  logic [XLEN-1:0] pc_q;
  logic [4:0]      rs1_addr_q;
  logic [4:0]      rs2_addr_q;
  logic [XLEN-1:0] rs1_data_q;
  logic [XLEN-1:0] rs2_data_q;
  logic [XLEN-1:0] imm_q;
  logic [4:0]      rd_addr_q;
  logic [OPW-1:0]  alu_op_q;
  logic            src1_pc_q;
  logic            src2_imm_q;
  logic            reg_write_q;
  logic            mem_read_q;
  logic            mem_write_q;

  logic            lu_stall;
  logic            bubble;
  logic [XLEN-1:0] fwd_rs1;
  logic [XLEN-1:0] fwd_rs2;

`ifdef EX_FWD_EN
  // Only an in-flight load needs a bubble; everything else is covered by forwarding.
  assign lu_stall = bus.id_valid & valid_q & mem_read_q &
                    rd_hits(rd_addr_q, bus.id_rs1_addr, bus.id_rs2_addr);

  ex_fwd_mux #(.XLEN(XLEN)) u_fwd_rs1 (
    .rs_addr       (rs1_addr_q),
    .reg_data      (rs1_data_q),
    .mem_reg_write (bus.mem_reg_write),
    .mem_rd_addr   (bus.mem_rd_addr),
    .mem_rd_data   (bus.mem_rd_data),
    .wb_reg_write  (bus.wb_reg_write),
    .wb_rd_addr    (bus.wb_rd_addr),
    .wb_rd_data    (bus.wb_rd_data),
    .fwd_data      (fwd_rs1)
  );

  ex_fwd_mux #(.XLEN(XLEN)) u_fwd_rs2 (
    .rs_addr       (rs2_addr_q),
    .reg_data      (rs2_data_q),
    .mem_reg_write (bus.mem_reg_write),
    .mem_rd_addr   (bus.mem_rd_addr),
    .mem_rd_data   (bus.mem_rd_data),
    .wb_reg_write  (bus.wb_reg_write),
    .wb_rd_addr    (bus.wb_rd_addr),
    .wb_rd_data    (bus.wb_rd_data),
    .fwd_data      (fwd_rs2)
  );
`else
  // Without forwarding, hold ID until every older writer of a source has reached the RF.
  assign lu_stall = bus.id_valid & (
      (valid_q & (reg_write_q | mem_read_q) &
       rd_hits(rd_addr_q, bus.id_rs1_addr, bus.id_rs2_addr)) |
      (bus.mem_reg_write & rd_hits(bus.mem_rd_addr, bus.id_rs1_addr, bus.id_rs2_addr)) |
      (bus.wb_reg_write & rd_hits(bus.wb_rd_addr, bus.id_rs1_addr, bus.id_rs2_addr)));

  assign fwd_rs1 = rs1_data_q;
  assign fwd_rs2 = rs2_data_q;

  logic unused_fwd;
  assign unused_fwd = ^{bus.mem_rd_data, bus.wb_rd_data, rs1_addr_q, rs2_addr_q};
`endif

  assign bubble = bus.ex_flush | (~bus.ex_hold & lu_stall);

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q     <= 1'b0;
      pc_q        <= '0;
      rs1_addr_q  <= '0;
      rs2_addr_q  <= '0;
      rs1_data_q  <= '0;
      rs2_data_q  <= '0;
      imm_q       <= '0;
      rd_addr_q   <= '0;
      alu_op_q    <= '0;
      src1_pc_q   <= 1'b0;
      src2_imm_q  <= 1'b0;
      reg_write_q <= 1'b0;
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
    end else if (bubble) begin
      // Data fields are left as-is; they are don't-care while the slot is invalid.
      valid_q     <= 1'b0;
      alu_op_q    <= OPW'(AluAdd);
      reg_write_q <= 1'b0;
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
    end else if (!bus.ex_hold) begin
      valid_q     <= bus.id_valid;
      pc_q        <= bus.id_pc;
      rs1_addr_q  <= bus.id_rs1_addr;
      rs2_addr_q  <= bus.id_rs2_addr;
      rs1_data_q  <= bus.id_rs1_data;
      rs2_data_q  <= bus.id_rs2_data;
      imm_q       <= bus.id_imm;
      rd_addr_q   <= bus.id_rd_addr;
      alu_op_q    <= bus.id_alu_op;
      src1_pc_q   <= bus.id_src1_pc;
      src2_imm_q  <= bus.id_src2_imm;
      reg_write_q <= bus.id_reg_write;
      mem_read_q  <= bus.id_mem_read;
      mem_write_q <= bus.id_mem_write;
    end
  end

  assign bus.ex_valid       = valid_q;
  assign bus.ex_alu_op      = alu_op_q;
  assign bus.ex_pc          = pc_q;
  assign bus.ex_rd_addr     = rd_addr_q;
  assign bus.ex_reg_write   = reg_write_q & valid_q;
  assign bus.ex_mem_read    = mem_read_q & valid_q;
  assign bus.ex_mem_write   = mem_write_q & valid_q;
  assign bus.ex_op1         = src1_pc_q ? pc_q : fwd_rs1;
  assign bus.ex_op2         = src2_imm_q ? imm_q : fwd_rs2;
  assign bus.ex_store_data  = fwd_rs2;
  assign bus.load_use_stall = lu_stall;

endmodule

// File: doc/id_ex_stage.md
# id_ex_stage

ID/EX pipeline register plus EX-side operand forwarding for the 5-stage RV32I pipeline. Captures decoded instruction fields from ID each cycle and resolves forwarded register values from MEM and WB. Produces the two ALU operands, the 5-bit ALUOp and the store data consumed by the EX-stage ALU. Also detects load-use hazards and inserts one bubble.

## Interface
Parameters:
- XLEN, 32, datapath width
- OPW, 5, ALUOp width

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- id_valid  in  1  ID holds a valid instruction
- id_pc  in  32  instruction PC
- id_rs1_addr, id_rs2_addr  in  5  source register indices
- id_rs1_data, id_rs2_data  in  32  register-file read data
- id_imm  in  32  sign-extended immediate
- id_rd_addr  in  5  destination index
- id_alu_op  in  5  ALUOp code
- id_src1_pc  in  1  operand 1 = PC
- id_src2_imm  in  1  operand 2 = immediate
- id_reg_write, id_mem_read, id_mem_write  in  1  control bits
- ex_hold  in  1  downstream stall; freeze EX contents
- ex_flush  in  1  kill the EX slot (branch/jump redirect)
- mem_reg_write  in  1  MEM-stage instruction writes rd
- mem_rd_addr  in  5  MEM-stage rd
- mem_rd_data  in  32  MEM-stage ALU result
- wb_reg_write  in  1  WB-stage instruction writes rd
- wb_rd_addr  in  5  WB-stage rd
- wb_rd_data  in  32  WB-stage write-back data
- ex_valid  out  1  EX slot valid
- ex_alu_op  out  5  to ALU ALUOp
- ex_op1, ex_op2  out  32  to ALU rs1_data / rs2_data
- ex_store_data  out  32  forwarded rs2 value for stores
- ex_rd_addr  out  5  destination index
- ex_reg_write, ex_mem_read, ex_mem_write  out  1  gated control
- ex_pc  out  32  registered PC
- load_use_stall  out  1  to hazard unit: hold IF/ID this cycle

## Operation
- Register update priority on each clk edge:
  - rst: ex_valid and all control bits cleared; ex_alu_op, ex_pc, rd and data fields set to 0.
  - ex_flush: bubble.
  - ex_hold: keep all contents.
  - load_use_stall: bubble.
  - Otherwise: load all id_* fields, with ex_valid = id_valid.
- Bubble: ex_valid, ex_reg_write, ex_mem_read and ex_mem_write all 0; ex_alu_op = ADD; other fields don't-care.
- ex_reg_write, ex_mem_read and ex_mem_write are output ANDed with ex_valid.
- load_use_stall (combinational) = ex_valid & ex_mem_read & ex_rd_addr≠0 & id_valid & (ex_rd_addr==id_rs1_addr | ex_rd_addr==id_rs2_addr).
  - Matches against unused sources are accepted (conservative).
- Forwarding (combinational, on the registered rs addresses/data), per source:
  - MEM match: mem_reg_write & mem_rd_addr≠0 & mem_rd_addr==rs.
  - Else WB match: same rule with wb_*.
  - Else the registered read data.
  - Index 0 always yields the registered value, never forwarded.
  - MEM beats WB on a double match.
- ex_op1 = ex_src1_pc ? ex_pc : fwd_rs1.
- ex_op2 = ex_src2_imm ? ex_imm : fwd_rs2.
- ex_store_data = fwd_rs2, always, independent of src2_imm.
- During ex_hold the forwarded operands keep re-evaluating against the current MEM/WB values.

## Timing
- ID→EX latency: 1 cycle. Forwarding muxes: 0 cycles (same-cycle path into the ALU).
- Load-use: one bubble cycle.
  - load_use_stall high in cycle N; EX holds a bubble in N+1.
  - The dependent instruction enters EX in N+2 and takes the load data via WB forwarding.
- ex_flush together with ex_hold: flush wins.
- ex_flush together with load_use_stall: flush wins; the bubble is identical either way.
- rst mid-stall or mid-flush: all outputs return to reset values on the next edge. load_use_stall goes low because ex_valid = 0.

## Configuration
- EX_FWD_EN defined: forwarding as described above.
- EX_FWD_EN undefined:
  - fwd_rs1 and fwd_rs2 are the registered read data only; the mem_* and wb_* inputs are unused.
  - load_use_stall is extended to any valid EX, MEM or WB writer whose rd matches an ID source.
  - The register file must write-first for this to be sufficient.

## Structure
- Shared header (existing ALUOp `define set): the ALUOp codes (ADD used for bubbles) and the 2-bit forward-select encodings FWD_REG / FWD_MEM / FWD_WB.
- One sub-module, ex_fwd_mux: combinational per-operand source selection, instantiated twice (rs1, rs2).

## Test plan
- ADD x3,x1,x2 with rf x1=5, x2=7, no hazards → next cycle ex_op1=5, ex_op2=7, ex_alu_op=ADD, ex_valid=1.
- MEM has rd=x1 with value 0x100, WB has rd=x1 with value 0x200; EX uses x1 → ex_op1=0x100 (MEM priority).
- EX holds LW x4; ID presents ADD x5,x4,x4 → load_use_stall=1 for one cycle, EX bubble (ex_reg_write=0), then the ADD enters EX.
- WB writes x0 with 0xDEAD; EX reads x0 (registered value 0) → ex_op1=0.
- ex_hold=1 for 3 cycles with changing id_* inputs → EX fields unchanged; ex_flush=1 with ex_hold=1 → ex_valid=0 next cycle.
- SW with src2_imm=1, imm=8, rs2 forwarded from MEM value 0x55 → ex_op2=8, ex_store_data=0x55.
